// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared constants for the button / reset conditioner.
// Holds the default timing constants, the reset sequencer state encoding and
// a small width helper used to size counters from their terminal values.
package input_conditioner_pkg;

    // 10 ms at 25 MHz: stable samples needed before a new level is accepted.
    localparam int DEB_CYCLES_DEFAULT  = 250000;
    // Minimum time sys_rst_out stays high once the reset button is released.
    localparam int RST_HOLD_DEFAULT    = 1024;
    // 1 s at 25 MHz: continuous press time that counts as a long press.
    localparam int LONG_CYCLES_DEFAULT = 25000000;
    // Debounce counter width; 2^18 comfortably exceeds DEB_CYCLES_DEFAULT.
    localparam int CNT_W_DEFAULT       = 18;

    // Reset sequencer state encoding.
    localparam logic [0:0] HOLD = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Bits needed to represent max_val (never less than one bit).
    function automatic int width_for(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// debounce_ch: one conditioned input channel.
// A raw active-low pin is brought into the clock domain with a two-flop
// synchroniser (preset to "released"), then debounced: the accepted level
// only changes after DEB_CYCLES consecutive samples disagree with it. Any
// agreeing sample restarts the count, so bounce shorter than that never
// reaches the output. Single-cycle press/release pulses are registered on
// the same edge the accepted level flips, so they line up with level_out.
//
// Handshake: none. level_out is a level; press_out / release_out are
// one-cycle strobes that are never high together.
module debounce_ch
    import input_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk_in,
    input  logic nrst_in,
    input  logic raw_n_in,
    output logic level_out,
    output logic press_out,
    output logic release_out
);

    // Last count value before the accepted level flips.
    localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             sample_pressed;
    logic [CNT_W-1:0] deb_cnt;

    // Two-flop synchroniser; both stages reset to the released pin value.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= raw_n_in;
            sync_q2 <= sync_q1;
        end
    end

    // Work in the pressed-is-one domain from here on.
    assign sample_pressed = ~sync_q2;

    // Debounce counter, accepted level and the edge strobes.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            deb_cnt     <= '0;
            level_out   <= 1'b0;
            press_out   <= 1'b0;
            release_out <= 1'b0;
        end else begin
            press_out   <= 1'b0;
            release_out <= 1'b0;
            if (sample_pressed == level_out) begin
                // Agreement with the accepted level restarts the count.
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_TERM) begin
                // Enough consecutive disagreeing samples: accept the new level.
                deb_cnt     <= '0;
                level_out   <= sample_pressed;
                press_out   <= sample_pressed;
                release_out <= ~sample_pressed;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: conditions the general push-buttons and the reset
// push-button ahead of the NES core.
// Every input gets its own debounce_ch (synchroniser + debouncer + edge
// strobes). The debounced reset button drives a two-state sequencer that
// produces a stretched sys_rst_out for CPU, PPU and cart.
//
// Optional feature, enabled by defining INPUT_CONDITIONER_LONG_PRESS_EN:
// adds parameter LONG_CYCLES and output long_press_out, a one-cycle strobe
// per button after it has been held for LONG_CYCLES cycles, re-armed only
// by a release.
//
// Handshake: none. All outputs are levels or one-cycle strobes in the
// clk_in domain; no valid/ready flow control is involved.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEB_CYCLES      = DEB_CYCLES_DEFAULT,
    parameter int RST_HOLD_CYCLES = RST_HOLD_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT
`endif
) (
    input  logic             clk_in,
    input  logic             nrst_in,
    input  logic [N_BTN-1:0] btn_n_in,
    input  logic             rst_btn_n_in,
    output logic [N_BTN-1:0] btn_out,
    output logic [N_BTN-1:0] btn_press_out,
    output logic [N_BTN-1:0] btn_release_out,
    output logic             sys_rst_out,
    output logic             rst_done_out
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
    ,
    output logic [N_BTN-1:0] long_press_out
`endif
);

    // ------------------------------------------------------------------
    // General push-buttons
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_btn_ch (
            .clk_in      (clk_in),
            .nrst_in     (nrst_in),
            .raw_n_in    (btn_n_in[i]),
            .level_out   (btn_out[i]),
            .press_out   (btn_press_out[i]),
            .release_out (btn_release_out[i])
        );
    end

    // ------------------------------------------------------------------
    // Reset push-button
    // ------------------------------------------------------------------
    logic rst_level;
    logic rst_press;
    logic rst_release;

    debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_rst_ch (
        .clk_in      (clk_in),
        .nrst_in     (nrst_in),
        .raw_n_in    (rst_btn_n_in),
        .level_out   (rst_level),
        .press_out   (rst_press),
        .release_out (rst_release)
    );

    // The sequencer only needs the level and the press strobe; the release
    // strobe is kept for symmetry with the button channels.
    logic unused_rst_release;
    assign unused_rst_release = rst_release;

    // ------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------
    localparam int                HOLD_W    = width_for(RST_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(RST_HOLD_CYCLES - 1);

    logic [0:0]        seq_state;
    logic [HOLD_W-1:0] hold_cnt;

    // HOLD counts released cycles and leaves after RST_HOLD_CYCLES of them;
    // RUN falls back to HOLD on an accepted reset-button press.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            seq_state <= HOLD;
            hold_cnt  <= '0;
        end else if (seq_state == HOLD) begin
            if (rst_level) begin
                // Button still held: the hold time starts over.
                hold_cnt <= '0;
            end else if (hold_cnt == HOLD_TERM) begin
                seq_state <= RUN;
                hold_cnt  <= '0;
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end else begin
            if (rst_press) begin
                seq_state <= HOLD;
                hold_cnt  <= '0;
            end
        end
    end

    // The press strobe is ORed in so reset rises in the very cycle the press
    // is accepted, one cycle before the sequencer itself reaches HOLD. Both
    // terms are flop outputs, and the strobe only falls on the edge where
    // the state has already become HOLD.
    assign sys_rst_out  = (seq_state == HOLD) | rst_press;
    assign rst_done_out = ~sys_rst_out;

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
    // ------------------------------------------------------------------
    // Long-press detection
    // ------------------------------------------------------------------
    localparam int                LONG_W    = width_for(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_TERM = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] long_cnt [N_BTN];

    // Per-button held-time counter: strobe once at LONG_CYCLES, then park at
    // the saturation value until the debounced level drops.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            for (int i = 0; i < N_BTN; i++) begin
                long_cnt[i] <= '0;
            end
            long_press_out <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                long_press_out[i] <= 1'b0;
                if (!btn_out[i]) begin
                    long_cnt[i] <= '0;
                end else if (long_cnt[i] == LONG_TERM) begin
                    long_cnt[i]       <= LONG_SAT;
                    long_press_out[i] <= 1'b1;
                end else if (long_cnt[i] != LONG_SAT) begin
                    long_cnt[i] <= long_cnt[i] + LONG_W'(1);
                end
            end
        end
    end
`endif

endmodule
